parking_zone_manager: RTL
=========================

# parking_zone_manager

Parametrised two-class parking occupancy manager, the next generation of `parking_management_system`. It tracks university and general cars against a time-of-day capacity schedule, with a built-in hour counter. University capacity shrinks in steps during the afternoon and the freed spaces move to the general pool. The block grants or rejects every entry and flags invalid exits. It sits between the gate sensors and the display/billing logic.

## Interface
- `CNT_W`, 10: width of all counts and capacities.
- `TOTAL_CAP`, 700: total spaces, constant.
- `UNI_CAP_MAX`, 500: university capacity before release.
- `UNI_CAP_MIN`, 200: floor for university capacity.
- `REL_START`, 13: first hour (0..23) at which release applies.
- `REL_STEP`, 50: university spaces released per hour from `REL_START`.
- `TICKS_PER_HOUR`, 3600000: clock cycles per hour; must be ≥1.
- `START_HOUR`, 8: hour loaded on reset.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `car_entered` in 1: entry request, one event per cycle high.
- `car_exited` in 1: exit request, one event per cycle high.
- `is_uni_car_entered` in 1: class of entering car, 1 = university.
- `is_uni_car_exited` in 1: class of exiting car.
- `uni_parked_car` out CNT_W: university cars parked, all zones.
- `parked_car` out CNT_W: general cars parked.
- `uni_vacated_space` out CNT_W: free university-zone spaces.
- `vacated_space` out CNT_W: free general-zone spaces.
- `uni_is_vacated_space` out 1: `uni_vacated_space != 0`.
- `is_vacated_space` out 1: `vacated_space != 0`.
- `entry_granted` out 1: one-cycle pulse, entry accepted.
- `entry_rejected` out 1: one-cycle pulse, entry refused.
- `exit_error` out 1: one-cycle pulse, exit with no matching car.
- `hour` out 5: current hour, 0..23.

## Operation
- State registers:
  - `uni_zone_occ`, university cars in the university zone.
  - `uni_borrow`, university cars in the general zone.
  - `gen_occ`, general cars.
  - `hour`.
  - Tick prescaler.
- University zone capacity `uni_cap`:
  - Equals `UNI_CAP_MAX` for `hour < REL_START`.
  - Otherwise `max(UNI_CAP_MIN, UNI_CAP_MAX - REL_STEP*(hour-REL_START+1))`.
  - Compute with CNT_W+6 bits before saturating.
- General capacity: `gen_cap = TOTAL_CAP - uni_cap`.
- `uni_parked_car = uni_zone_occ + uni_borrow`.
- `parked_car = gen_occ`.
- `uni_vacated_space = uni_cap - uni_zone_occ`, saturated at 0.
- `vacated_space = gen_cap - gen_occ - uni_borrow`, saturated at 0.
- Entry, university car:
  - If university space is free, increment `uni_zone_occ`.
  - Otherwise, see Configuration.
- Entry, general car: if general space is free, increment `gen_occ`; otherwise reject.
- Exit, university car: decrement `uni_borrow` if nonzero, else `uni_zone_occ`. If both are 0, raise `exit_error` and change nothing.
- Exit, general car: decrement `gen_occ`. If it is 0, raise `exit_error`.
- Capacity shrink below current occupancy: no eviction. Vacated space reads 0, and entries are rejected until occupancy drops below capacity.
- Simultaneous entry and exit in one cycle:
  - Both are processed.
  - The entry decision uses pre-exit occupancy.
  - The counters apply the net result.

## Timing
- All state updates on the rising `clk` edge.
- Outputs are registers or combinational functions of registers, valid 1 cycle after the request edge.
- Pulses are high for exactly the cycle after the sampled request.
- Prescaler counts 0..TICKS_PER_HOUR-1. On wrap, `hour` increments, and 23 wraps to 0. At hour 0, `uni_cap` returns to `UNI_CAP_MAX`.
- Reset values:
  - All counts and pulses 0.
  - `hour = START_HOUR`.
  - Prescaler 0.
  - `uni_vacated_space = UNI_CAP_MAX` if `START_HOUR < REL_START`.
  - `vacated_space = TOTAL_CAP - uni_cap`.
  - Both flags 1.
- Reset asserted mid-operation clears state immediately and asynchronously. Requests are ignored while reset is high.

## Configuration
- Macro: `UNI_OVERFLOW_EN`.
- Defined: a university entry with the university zone full takes a general space if `vacated_space != 0`, incrementing `uni_borrow`, and is granted. It is rejected otherwise.
- Undefined: such an entry is rejected. `uni_borrow` is tied to 0 and its logic is removed.

## Test plan
Bench parameters: `TOTAL_CAP=6`, `UNI_CAP_MAX=4`, `UNI_CAP_MIN=2`, `REL_START=13`, `REL_STEP=1`, `TICKS_PER_HOUR=5`, `START_HOUR=12`.
- Reset, then idle 1 cycle -> all counts 0, `uni_vacated_space=4`, `vacated_space=2`, `hour=12`, both flags 1.
- 5 university entries, `UNI_OVERFLOW_EN` defined -> 5 grants, `uni_parked_car=5`, `uni_vacated_space=0`, `vacated_space=1`. Then one university exit -> `vacated_space=2`, `uni_vacated_space=0`.
- Same 5 entries, macro undefined -> 4 grants, then 1 reject; `uni_parked_car=4`.
- General exit with `parked_car=0` -> `exit_error` pulse, all counts unchanged.
- Park 4 university cars, run 5 ticks to hour 13 -> `uni_cap=3`, `uni_vacated_space=0`, `vacated_space=3`. Next university entry without overflow is rejected.
- Run to hour 15 -> `uni_cap` saturates at 2. At hour 0 -> `uni_vacated_space=4-uni_zone_occ`.
- Simultaneous general entry and exit with general zone full -> entry rejected, exit applied, `parked_car` decrements by 1.
- Reset asserted mid-stream -> all counts 0 and `hour=12` without waiting for a clock edge.

Source files
------------

// File: rtl/parking_zone_manager.sv
// parking_zone_manager
// Two-class (university / general) parking occupancy manager with a built-in
// hour counter and an afternoon university-capacity release schedule.
// Optional feature: define UNI_OVERFLOW_EN to let university cars borrow
// general-zone spaces when the university zone is full. Without the macro the
// borrow counter is tied to zero and such entries are rejected.
module parking_zone_manager #(
    parameter int CNT_W          = 10,
    parameter int TOTAL_CAP      = 700,
    parameter int UNI_CAP_MAX    = 500,
    parameter int UNI_CAP_MIN    = 200,
    parameter int REL_START      = 13,
    parameter int REL_STEP       = 50,
    parameter int TICKS_PER_HOUR = 3600000,
    parameter int START_HOUR     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_entered,
    input  logic             car_exited,
    input  logic             is_uni_car_entered,
    input  logic             is_uni_car_exited,
    output logic [CNT_W-1:0] uni_parked_car,
    output logic [CNT_W-1:0] parked_car,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic [CNT_W-1:0] vacated_space,
    output logic             uni_is_vacated_space,
    output logic             is_vacated_space,
    output logic             entry_granted,
    output logic             entry_rejected,
    output logic             exit_error,
    output logic [4:0]       hour
);

    // Request/response contract: car_entered / car_exited are single-cycle
    // events sampled on every rising edge (no back-pressure, each high cycle is
    // one car). The decision pulses entry_granted / entry_rejected / exit_error
    // are high for exactly the cycle after the sampled request; counts and
    // free-space outputs reflect the request from that same cycle onward.

    localparam int WW   = CNT_W + 6;
    localparam int PS_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

    logic [PS_W-1:0]  ps_q, ps_d;
    logic [4:0]       hour_q, hour_d;
    logic [CNT_W-1:0] uni_zone_q, uni_zone_d;
    logic [CNT_W-1:0] gen_occ_q, gen_occ_d;
    logic [CNT_W-1:0] uni_borrow;
    logic             granted_q, granted_d;
    logic             rejected_q, rejected_d;
    logic             exit_err_q, exit_err_d;

    logic [WW-1:0]    rel_steps, rel_amount;
    logic [CNT_W-1:0] uni_cap, gen_cap, uni_vac, gen_vac;
    logic [CNT_W:0]   gen_used;
    logic             uni_free, gen_free;

`ifdef UNI_OVERFLOW_EN
    logic [CNT_W-1:0] uni_borrow_q, uni_borrow_d;

    // University cars parked in the general zone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) uni_borrow_q <= '0;
        else       uni_borrow_q <= uni_borrow_d;
    end

    assign uni_borrow = uni_borrow_q;
`else
    assign uni_borrow = '0;
`endif

    // University capacity schedule: full before the release hour, then shrinks
    // by REL_STEP per hour (inclusive of the release hour) down to the floor.
    always_comb begin
        rel_steps  = WW'(hour_q) - WW'(REL_START) + WW'(1);
        rel_amount = rel_steps * WW'(REL_STEP);
        if (hour_q < 5'(REL_START))
            uni_cap = CNT_W'(UNI_CAP_MAX);
        else if (rel_amount >= WW'(UNI_CAP_MAX - UNI_CAP_MIN))
            uni_cap = CNT_W'(UNI_CAP_MIN);
        else
            uni_cap = CNT_W'(WW'(UNI_CAP_MAX) - rel_amount);
    end

    // Free space per zone; occupancy above a freshly shrunk capacity reads 0
    always_comb begin
        gen_cap  = CNT_W'(TOTAL_CAP) - uni_cap;
        gen_used = {1'b0, gen_occ_q} + {1'b0, uni_borrow};
        gen_vac  = ({1'b0, gen_cap} > gen_used) ? gen_cap - gen_used[CNT_W-1:0] : '0;
        uni_vac  = (uni_cap > uni_zone_q) ? uni_cap - uni_zone_q : '0;
        uni_free = (uni_vac != '0);
        gen_free = (gen_vac != '0);
    end

    // Entry/exit decisions on pre-exit occupancy; counters take the net result
    always_comb begin
        uni_zone_d = uni_zone_q;
        gen_occ_d  = gen_occ_q;
`ifdef UNI_OVERFLOW_EN
        uni_borrow_d = uni_borrow_q;
`endif
        granted_d  = 1'b0;
        rejected_d = 1'b0;
        exit_err_d = 1'b0;

        if (car_entered) begin
            if (is_uni_car_entered) begin
                if (uni_free) begin
                    uni_zone_d = uni_zone_d + CNT_W'(1);
                    granted_d  = 1'b1;
                end
`ifdef UNI_OVERFLOW_EN
                else if (gen_free) begin
                    uni_borrow_d = uni_borrow_d + CNT_W'(1);
                    granted_d    = 1'b1;
                end
`endif
                else begin
                    rejected_d = 1'b1;
                end
            end else if (gen_free) begin
                gen_occ_d = gen_occ_d + CNT_W'(1);
                granted_d = 1'b1;
            end else begin
                rejected_d = 1'b1;
            end
        end

        if (car_exited) begin
            if (is_uni_car_exited) begin
`ifdef UNI_OVERFLOW_EN
                if (uni_borrow_q != '0)
                    uni_borrow_d = uni_borrow_d - CNT_W'(1);
                else
`endif
                if (uni_zone_q != '0)
                    uni_zone_d = uni_zone_d - CNT_W'(1);
                else
                    exit_err_d = 1'b1;
            end else if (gen_occ_q != '0) begin
                gen_occ_d = gen_occ_d - CNT_W'(1);
            end else begin
                exit_err_d = 1'b1;
            end
        end
    end

    // Hour prescaler and 0..23 hour counter
    always_comb begin
        ps_d   = ps_q + PS_W'(1);
        hour_d = hour_q;
        if (ps_q == PS_W'(TICKS_PER_HOUR - 1)) begin
            ps_d   = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q       <= '0;
            hour_q     <= 5'(START_HOUR);
            uni_zone_q <= '0;
            gen_occ_q  <= '0;
            granted_q  <= 1'b0;
            rejected_q <= 1'b0;
            exit_err_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            hour_q     <= hour_d;
            uni_zone_q <= uni_zone_d;
            gen_occ_q  <= gen_occ_d;
            granted_q  <= granted_d;
            rejected_q <= rejected_d;
            exit_err_q <= exit_err_d;
        end
    end

    assign uni_parked_car       = uni_zone_q + uni_borrow;
    assign parked_car           = gen_occ_q;
    assign uni_vacated_space    = uni_vac;
    assign vacated_space        = gen_vac;
    assign uni_is_vacated_space = uni_free;
    assign is_vacated_space     = gen_free;
    assign entry_granted        = granted_q;
    assign entry_rejected       = rejected_q;
    assign exit_error           = exit_err_q;
    assign hour                 = hour_q;

endmodule
